// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, instruction field positions and
// the program-load encoder state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: places instruction fields into a 32-bit MIPS word
// and flags whether the opcode belongs to the supported set.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    word      = '0;
    supported = 1'b1;
    word[OP_MSB:OP_LSB] = op;
    word[RT_MSB:RT_LSB] = rt;
    case (op)
      OP_RTYPE: begin
        word[RS_MSB:RS_LSB]       = rs;
        word[RD_MSB:RD_LSB]       = rd;
        word[SHAMT_MSB:SHAMT_LSB] = shamt;
        word[FUNCT_MSB:FUNCT_LSB] = funct;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
        word[RS_MSB:RS_LSB]   = rs;
        word[IMM_MSB:IMM_LSB] = imm;
      end
      // LUI has no source register; the rs slot stays zero.
      OP_LUI: word[IMM_MSB:IMM_LSB] = imm;
      default: begin
        word      = '0;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts field bundles, packs them and writes the
// words sequentially into instruction memory from BASE_ADDR.
//
// state   | meaning
// IDLE    | reset state, no session open, in_ready low
// LOAD    | session open, accepting one bundle per cycle
// FULL    | DEPTH words accepted, waiting for the next start
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  err,
  output logic [5:0]            bad_op
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

  enc_state_t            state;
  logic [31:0]           packed_word;
  logic                  supported;
  logic                  accept;
  logic [ADDR_WIDTH:0]   count_inc;

  instr_field_packer u_packer (
    .op        (in_op),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .funct     (in_funct),
    .imm       (in_imm),
    .word      (packed_word),
    .supported (supported)
  );

  assign accept    = in_valid && in_ready;
  assign count_inc = word_count + ONE_CNT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      bad_op     <= '0;
    end else begin
      mem_we <= 1'b0;
      // start wins over everything, including a bundle offered this cycle
      if (start) begin
        state      <= ST_LOAD;
        in_ready   <= 1'b1;
        word_count <= '0;
        full       <= 1'b0;
        err        <= 1'b0;
        bad_op     <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              if (supported) begin
                mem_we     <= 1'b1;
                mem_addr   <= BASE + word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= DATA_WIDTH'(packed_word);
                word_count <= count_inc;
                if (count_inc == DEPTH_CNT) begin
                  state    <= ST_FULL;
                  in_ready <= 1'b0;
                  full     <= 1'b1;
                end
              end else begin
                err <= 1'b1;
                if (!err) bad_op <= in_op;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default-sized and a 4-word instance share one
// stimulus stream and are checked every cycle against a session-level model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [5:0]  in_op, in_funct;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;

  logic        ready_a, we_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  wc_a;
  logic [5:0]  bad_a;

  logic        ready_b, we_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wc_b;
  logic [5:0]  bad_b;

  always #5 clk = ~clk;

  instr_encoder dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready_a),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .word_count(wc_a), .full(full_a), .err(err_a), .bad_op(bad_a)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(ready_b),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .word_count(wc_b), .full(full_b), .err(err_b), .bad_op(bad_b)
  );

  int n_vec = 0;
  int n_err = 0;

  int depth_m[2] = '{256, 4};
  int base_m[2]  = '{0, 2};
  bit m_open[2], m_we[2], m_err[2];
  int m_count[2], m_addr[2], m_bad[2];
  logic [31:0] m_wdata[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_supported(input int op);
    return op inside {0, 4, 5, 8, 12, 13, 15, 35, 43};
  endfunction

  function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int fn,
                                           input int imm);
    logic [31:0] w;
    w = 32'(op) << 26;
    if (op == 0)
      w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (op == 15)
      w = w | (32'(rt) << 16) | 32'(imm);
    else
      w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return w;
  endfunction

  function automatic bit m_ready(input int c);
    return m_open[c] && (m_count[c] < depth_m[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_open[c] = 0; m_we[c] = 0; m_err[c] = 0;
      m_count[c] = 0; m_addr[c] = 0; m_bad[c] = 0; m_wdata[c] = '0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      bit rdy;
      rdy = m_ready(c);
      m_we[c] = 0;
      if (start) begin
        m_open[c] = 1; m_count[c] = 0; m_err[c] = 0; m_bad[c] = 0;
      end else if (in_valid && rdy) begin
        if (ref_supported(int'(in_op))) begin
          m_we[c]    = 1;
          m_addr[c]  = (base_m[c] + m_count[c]) % depth_m[c];
          m_wdata[c] = ref_word(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                                int'(in_shamt), int'(in_funct), int'(in_imm));
          m_count[c]++;
        end else begin
          if (!m_err[c]) m_bad[c] = int'(in_op);
          m_err[c] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("a_ready", 32'(ready_a), 32'(m_ready(0)));
    check("a_we",    32'(we_a),    32'(m_we[0]));
    check("a_addr",  32'(addr_a),  32'(m_addr[0]));
    check("a_wdata", wdata_a,      m_wdata[0]);
    check("a_count", 32'(wc_a),    32'(m_count[0]));
    check("a_full",  32'(full_a),  32'(m_count[0] == depth_m[0]));
    check("a_err",   32'(err_a),   32'(m_err[0]));
    check("a_bad",   32'(bad_a),   32'(m_bad[0]));
    check("b_ready", 32'(ready_b), 32'(m_ready(1)));
    check("b_we",    32'(we_b),    32'(m_we[1]));
    check("b_addr",  32'(addr_b),  32'(m_addr[1]));
    check("b_wdata", wdata_b,      m_wdata[1]);
    check("b_count", 32'(wc_b),    32'(m_count[1]));
    check("b_full",  32'(full_b),  32'(m_count[1] == depth_m[1]));
    check("b_err",   32'(err_b),   32'(m_err[1]));
    check("b_bad",   32'(bad_b),   32'(m_bad[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1 check_all();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    reset = 1'b0;
  endtask

  task automatic set_fields(input int op, input int rs, input int rt, input int rd,
                            input int sh, input int fn, input int imm);
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm);
  endtask

  int ops[12] = '{0, 4, 5, 8, 12, 13, 15, 35, 43, 2, 3, 63};

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3 check_all();
    @(posedge clk);
    #1 check_all();
    reset = 1'b0;

    // bundle offered while idle and during the start cycle is not taken
    set_fields(8, 0, 8, 0, 0, 0, 5);
    in_valid = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("plan_addi_we",    32'(we_a), 32'd1);
    check("plan_addi_addr",  32'(addr_a), 32'd0);
    check("plan_addi_wdata", wdata_a, 32'h20080005);
    check("plan_addi_count", 32'(wc_a), 32'd1);
    in_valid = 1'b0;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    set_fields(0, 8, 9, 10, 0, 6'h20, 0);
    in_valid = 1'b1;
    tick();
    check("plan_rtype_wdata", wdata_a, 32'h01095020);
    check("plan_rtype_addr",  32'(addr_a), 32'd0);
    set_fields(35, 29, 8, 0, 0, 0, 4);
    tick();
    check("plan_lw_wdata", wdata_a, 32'h8FA80004);
    check("plan_lw_addr",  32'(addr_a), 32'd1);
    set_fields(15, 7, 1, 0, 0, 0, 16'h1001);
    tick();
    check("plan_lui_wdata", wdata_a, 32'h3C011001);
    in_valid = 1'b0;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    set_fields(2, 1, 2, 3, 4, 5, 6);
    tick();
    check("plan_bad1_we", 32'(we_a), 32'd0);
    set_fields(3, 1, 2, 3, 4, 5, 6);
    tick();
    check("plan_bad2_bad", 32'(bad_a), 32'd2);
    set_fields(13, 1, 2, 0, 0, 0, 16'h00ff);
    tick();
    check("plan_ori_addr",  32'(addr_a), 32'd0);
    check("plan_ori_wdata", wdata_a, 32'h342200FF);
    check("plan_ori_err",   32'(err_a), 32'd1);
    in_valid = 1'b0;
    tick();

    // fill both instances; the small one wraps 2,3,0,1 and saturates first
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_fields(8, i % 32, (i + 1) % 32, 0, 0, 0, i);
      tick();
      if (i == 3) begin
        check("plan_wrap_addr",  32'(addr_b), 32'd1);
        check("plan_wrap_full",  32'(full_b), 32'd1);
        check("plan_wrap_ready", 32'(ready_b), 32'd0);
      end
    end
    check("plan_fill_full_a", 32'(full_a), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("plan_restart_addr_b", 32'(addr_b), 32'd2);

    tick();
    pulse_reset();
    check("plan_reset_we", 32'(we_a), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("plan_after_reset_addr_b", 32'(addr_b), 32'd2);
    in_valid = 1'b0;

    for (int i = 0; i < 400; i++) begin
      set_fields(ops[$urandom_range(0, 11)], $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                 $urandom_range(0, 65535));
      in_valid = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load block for the MIPS processor. Accepts instruction fields (opcode, registers, shamt, funct, immediate) over a valid/ready handshake, packs them into 32-bit MIPS words, and writes them sequentially into instruction memory starting at a base address. It is the encode-side counterpart of the opcode decoder in the control unit and supports the same opcode set. It sits between the testbench or boot loader and the instruction memory write port.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32.
- ADDR_WIDTH, 8, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that opens a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_op  in  6  opcode.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function code.
- in_imm  in  16  I-type immediate.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_WIDTH  write word address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_WIDTH+1  supported words accepted this session.
- full  out  1  DEPTH words accepted.
- err  out  1  sticky flag: an unsupported opcode was received.
- bad_op  out  6  opcode of the first unsupported bundle.

## Operation
- FSM states:
  - IDLE: reset state; in_ready=0.
  - LOAD: accepting bundles; in_ready=1.
  - FULL: in_ready=0.
- start has priority over every other event in every state. It moves the FSM to LOAD, clears word_count, err and bad_op, and drops any bundle presented in the same cycle.
- Accept: a bundle is accepted when in_valid && in_ready in LOAD.
- Encoding of supported opcodes:
  - R-type (0x00): {op, rs, rt, rd, shamt, funct}.
  - ADDI 0x08, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05: {op, rs, rt, imm}.
  - LUI 0x0F: {op, 5'b0, rt, imm}. in_rs is ignored and forced to 0.
- Supported accept:
  - write scheduled at address BASE_ADDR + word_count, truncated to ADDR_WIDTH so it wraps modulo DEPTH.
  - word_count increments by 1.
  - When word_count reaches DEPTH, the FSM enters FULL.
- Unsupported accept:
  - The bundle is consumed (handshake completes).
  - No write; word_count unchanged.
  - err set. bad_op is captured only if err was previously 0.
- full = (word_count == DEPTH).

## Timing
- Reset values:
  - state IDLE; in_ready 0; mem_we 0; mem_addr 0; mem_wdata 0.
  - word_count 0; full 0; err 0; bad_op 0.
- Latency: a supported accept in cycle N produces mem_we=1 with mem_addr/mem_wdata valid in cycle N+1, for exactly one cycle. All outputs are registered.
- Throughput: one bundle per cycle, back-to-back, with no bubbles.
- in_ready is a registered state decode and does not depend on in_valid.
- After the accept that brings word_count to DEPTH, in_ready=0 in the next cycle. That final word's write still issues in the next cycle.
- A write registered in the cycle before a start still issues during the start cycle.
- reset mid-session aborts any pending write immediately; mem_we goes to 0 asynchronously.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Structure
- Shared package mips_isa_pkg, to be used by both the control decoder and this block:
  - opcode localparams;
  - field bit positions (op 31:26, rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0, imm 15:0);
  - FSM state encoding.
- Sub-module instr_field_packer: purely combinational. Inputs are the fields; outputs are the 32-bit word and a supported flag. The encoder registers its outputs.

## Test plan
- start, then ADDI op=0x08 rs=0 rt=8 imm=5 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x20080005, word_count=1.
- R-type op=0 rs=8 rt=9 rd=10 shamt=0 funct=0x20, then LW op=0x23 rs=29 rt=8 imm=4 back-to-back -> writes 0x01095020 @0, then 0x8FA80004 @1, on consecutive cycles.
- LUI op=0x0F rs=7 rt=1 imm=0x1001 -> mem_wdata=0x3C011001 (rs forced to 0).
- Unsupported op=0x02, then op=0x03, then ORI -> no write for either unsupported bundle; err=1, bad_op=0x02; ORI written at addr 0.
- ADDR_WIDTH=2, BASE_ADDR=2, five bundles held valid -> four writes at addrs 2, 3, 0, 1; full=1; in_ready=0; fifth bundle stalls until start.
- reset asserted the cycle after an accept -> mem_we=0 with no write; a following start plus one bundle writes at BASE_ADDR.
